jtag_user_dr: RTL and testbench
===============================

JTAG_USER_DR -- requirements
Module: jtag_user_dr

Interface
REQ-001 Parameter DR_W, default 32: data-register width in bits (>=2).
REQ-002 Parameter IR_W, default 4: instruction-register width in bits (>=2).
REQ-003 Parameter CHAINS, default 2: number of user data chains (1..2^IR_W-1).
REQ-004 Port clk, input, 1: sole clock; all state is updated on its rising edge.
REQ-005 Port rst, input, 1: reset; one clock, reset asynchronous and active-high.
REQ-006 Port tck, input, 1: JTAG clock from the BSCAN primitive, asynchronous to clk, frequency <= clk/4.
REQ-007 Port tms, input, 1: JTAG mode select, asynchronous.
REQ-008 Port tdi, input, 1: JTAG serial data in, asynchronous.
REQ-009 Port tdo, output, 1: JTAG serial data out, registered in the clk domain.
REQ-010 Port cap_data, input, CHAINS*DR_W: per-chain capture word; chain k occupies bits [k*DR_W +: DR_W].
REQ-011 Port upd_valid, output, 1: one-cycle pulse marking a completed Update-DR on a user chain.
REQ-012 Port upd_chain, output, IR_W: chain index qualified by upd_valid.
REQ-013 Port upd_data, output, DR_W: shifted-in word qualified by upd_valid.
REQ-014 Port tap_state, output, 4: current TAP state encoding, for debug.

Function
REQ-015 tck, tms and tdi each pass through a 2-flop synchroniser; a tck rise or fall is detected from the synchronised tck against its previous value.
REQ-016 Every action below occurs in the clk cycle after edge detection, 3 clk cycles after the tck pin edge.
REQ-017 On each tck rise the 16-state IEEE 1149.1 TAP FSM advances from its current state using the synchronised tms. Encoding: TLR=0, RTI=1, SelDR=2, CapDR=3, ShDR=4, Ex1DR=5, PaDR=6, Ex2DR=7, UpdDR=8, SelIR=9, CapIR=10, ShIR=11, Ex1IR=12, PaIR=13, Ex2IR=14, UpdIR=15.
REQ-018 In TLR, ir is all-ones, which selects BYPASS.
REQ-019 Five consecutive tck rises with tms=1 reach TLR from any state.
REQ-020 Chain select: ir < CHAINS selects user chain ir; any other value selects BYPASS.
REQ-021 On a tck rise in CapDR, the DR shift register loads the selected chain's cap_data word; for BYPASS it loads a single 0.
REQ-022 On a tck rise in ShDR, the DR shifts right with tdi entering the MSB. The active length is DR_W for a user chain and 1 for BYPASS.
REQ-023 On a tck rise in CapIR, the IR shift register loads binary ...0001.
REQ-024 On a tck rise in ShIR, the IR shifts right with tdi entering bit IR_W-1.
REQ-025 On a tck rise in UpdIR, ir takes the IR shift register value.
REQ-026 On a tck rise in UpdDR with a user chain selected, the next cycle drives upd_valid=1 for exactly one clk, with upd_chain=ir and upd_data=DR.
REQ-027 BYPASS never pulses upd_valid.
REQ-028 upd_chain and upd_data hold their values until the next update.
REQ-029 On each tck fall, tdo is updated:
- in ShDR: DR bit 0;
- in ShIR: IR shift bit 0;
- otherwise: 0.
REQ-030 A tck rise and a tck fall are never detected in the same cycle; a glitch shorter than 2 clk may be missed and has no other effect.
REQ-031 tap_state always reflects the current FSM state.

Reset
REQ-032 While rst=1:
- FSM in TLR and tap_state=0;
- ir all-ones;
- DR and IR shift registers zero;
- synchroniser flops zero;
- tdo=0, upd_valid=0, upd_chain=0, upd_data=0.
REQ-033 rst asserted mid-shift aborts the scan with no upd_valid pulse.
REQ-034 After rst deasserts, the first detected tck rise is evaluated from TLR.

Verification
REQ-035 Reset then 5 tck cycles with tms=1 -> tap_state=0, ir=all-ones, no upd_valid.
REQ-036 Load IR=1, then a DR scan of 32 bits with tdi=0xA5A5_1234 LSB-first and cap_data chain1=0xDEADBEEF -> tdo streams 0xDEADBEEF LSB-first and one upd_valid with upd_chain=1, upd_data=0xA5A5_1234.
REQ-037 IR=0xF (BYPASS), shift 8 bits 0b10110010 -> tdo returns the same bits delayed by one tck, and no upd_valid.
REQ-038 IR scan -> tdo shows captured 0b0001 LSB-first.
REQ-039 DR scan through PaDR/Ex2DR with 10 pause tcks mid-shift -> the DR is unchanged while paused, and the final upd_data is correct.
REQ-040 rst pulsed after 16 of 32 DR shifts -> tap_state=0 immediately and no upd_valid; a following full scan operates normally.

Source files
------------

// File: rtl/jtag_user_dr.sv
// rtl/jtag_user_dr.sv - JTAG TAP with user data chains, oversampled in the clk domain
module jtag_user_dr #(
    parameter int DR_W   = 32,
    parameter int IR_W   = 4,
    parameter int CHAINS = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tck,
    input  logic                   tms,
    input  logic                   tdi,
    output logic                   tdo,
    input  logic [CHAINS*DR_W-1:0] cap_data,
    output logic                   upd_valid,
    output logic [IR_W-1:0]        upd_chain,
    output logic [DR_W-1:0]        upd_data,
    output logic [3:0]             tap_state
);

    typedef enum logic [3:0] {
        TLR    = 4'd0,
        RTI    = 4'd1,
        SEL_DR = 4'd2,
        CAP_DR = 4'd3,
        SH_DR  = 4'd4,
        EX1_DR = 4'd5,
        PA_DR  = 4'd6,
        EX2_DR = 4'd7,
        UPD_DR = 4'd8,
        SEL_IR = 4'd9,
        CAP_IR = 4'd10,
        SH_IR  = 4'd11,
        EX1_IR = 4'd12,
        PA_IR  = 4'd13,
        EX2_IR = 4'd14,
        UPD_IR = 4'd15
    } tap_state_t;

    localparam logic [IR_W-1:0] CHAINS_L = IR_W'(CHAINS);
    localparam logic [IR_W-1:0] IR_CAP   = IR_W'(1);

    logic [1:0]      tck_s;
    logic [1:0]      tms_s;
    logic [1:0]      tdi_s;
    logic            tck_q;
    logic            tck_rise;
    logic            tck_fall;
    tap_state_t      state_q;
    tap_state_t      state_d;
    logic [IR_W-1:0] ir;
    logic [IR_W-1:0] ir_sr;
    logic [DR_W-1:0] dr_sr;
    logic [DR_W-1:0] cap_word;
    logic            user_sel;

    // Two-flop synchronisers for the JTAG pins plus a delayed copy of tck for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tck_s <= '0;
            tms_s <= '0;
            tdi_s <= '0;
            tck_q <= 1'b0;
        end else begin
            tck_s <= {tck_s[0], tck};
            tms_s <= {tms_s[0], tms};
            tdi_s <= {tdi_s[0], tdi};
            tck_q <= tck_s[1];
        end
    end

    // A rise and a fall are mutually exclusive because both compare the same two bits
    assign tck_rise  = tck_s[1] & ~tck_q;
    assign tck_fall  = ~tck_s[1] & tck_q;
    assign user_sel  = (ir < CHAINS_L);
    assign tap_state = state_q;

    // Capture word of the currently selected chain; unused when BYPASS is selected
    always_comb begin
        cap_word = '0;
        for (int k = 0; k < CHAINS; k++) begin
            if (ir == IR_W'(k)) begin
                cap_word = cap_data[k*DR_W +: DR_W];
            end
        end
    end

    // TAP state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= TLR;
        end else begin
            state_q <= state_d;
        end
    end

    // TAP next-state: advances only on a detected tck rise, steered by synchronised tms
    always_comb begin
        state_d = state_q;
        if (tck_rise) begin
            case (state_q)
                TLR:     state_d = tms_s[1] ? TLR    : RTI;
                RTI:     state_d = tms_s[1] ? SEL_DR : RTI;
                SEL_DR:  state_d = tms_s[1] ? SEL_IR : CAP_DR;
                CAP_DR:  state_d = tms_s[1] ? EX1_DR : SH_DR;
                SH_DR:   state_d = tms_s[1] ? EX1_DR : SH_DR;
                EX1_DR:  state_d = tms_s[1] ? UPD_DR : PA_DR;
                PA_DR:   state_d = tms_s[1] ? EX2_DR : PA_DR;
                EX2_DR:  state_d = tms_s[1] ? UPD_DR : SH_DR;
                UPD_DR:  state_d = tms_s[1] ? SEL_DR : RTI;
                SEL_IR:  state_d = tms_s[1] ? TLR    : CAP_IR;
                CAP_IR:  state_d = tms_s[1] ? EX1_IR : SH_IR;
                SH_IR:   state_d = tms_s[1] ? EX1_IR : SH_IR;
                EX1_IR:  state_d = tms_s[1] ? UPD_IR : PA_IR;
                PA_IR:   state_d = tms_s[1] ? EX2_IR : PA_IR;
                EX2_IR:  state_d = tms_s[1] ? UPD_IR : SH_IR;
                UPD_IR:  state_d = tms_s[1] ? SEL_DR : RTI;
                default: state_d = TLR;
            endcase
        end
    end

    // Instruction path: capture/shift/update; entering TLR forces BYPASS
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir    <= '1;
            ir_sr <= '0;
        end else if (tck_rise) begin
            case (state_q)
                CAP_IR:  ir_sr <= IR_CAP;
                SH_IR:   ir_sr <= {tdi_s[1], ir_sr[IR_W-1:1]};
                default: ir_sr <= ir_sr;
            endcase
            if (state_d == TLR) begin
                ir <= '1;
            end else if (state_q == UPD_IR) begin
                ir <= ir_sr;
            end
        end
    end

    // Data path: a user chain is DR_W bits long, BYPASS is the single bit dr_sr[0]
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dr_sr <= '0;
        end else if (tck_rise) begin
            if (state_q == CAP_DR) begin
                dr_sr <= user_sel ? cap_word : '0;
            end else if (state_q == SH_DR) begin
                dr_sr <= user_sel ? {tdi_s[1], dr_sr[DR_W-1:1]}
                                  : {{(DR_W-1){1'b0}}, tdi_s[1]};
            end
        end
    end

    // Update handshake: one-cycle pulse, chain and data held until the next update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upd_valid <= 1'b0;
            upd_chain <= '0;
            upd_data  <= '0;
        end else begin
            upd_valid <= 1'b0;
            if (tck_rise && state_q == UPD_DR && user_sel) begin
                upd_valid <= 1'b1;
                upd_chain <= ir;
                upd_data  <= dr_sr;
            end
        end
    end

    // tdo changes on tck fall so it is stable for the next rise of the external sampler
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tdo <= 1'b0;
        end else if (tck_fall) begin
            case (state_q)
                SH_DR:   tdo <= dr_sr[0];
                SH_IR:   tdo <= ir_sr[0];
                default: tdo <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_user_dr.sv
// tb/tb_jtag_user_dr.sv - randomized self-checking bench for jtag_user_dr
module tb_jtag_user_dr;
    localparam int DR_W   = 32;
    localparam int IR_W   = 4;
    localparam int CHAINS = 2;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   tck = 1'b0;
    logic                   tms = 1'b0;
    logic                   tdi = 1'b0;
    logic                   tdo;
    logic [CHAINS*DR_W-1:0] cap_data = '0;
    logic                   upd_valid;
    logic [IR_W-1:0]        upd_chain;
    logic [DR_W-1:0]        upd_data;
    logic [3:0]             tap_state;

    jtag_user_dr #(.DR_W(DR_W), .IR_W(IR_W), .CHAINS(CHAINS)) dut (
        .clk(clk), .rst(rst), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo),
        .cap_data(cap_data), .upd_valid(upd_valid), .upd_chain(upd_chain),
        .upd_data(upd_data), .tap_state(tap_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    // IEEE 1149.1 transition table, indexed by state, for tms=0 and tms=1
    int nxt0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
    int nxt1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

    int              m_state;
    logic [IR_W-1:0] m_ir;
    logic [IR_W-1:0] m_irsr;
    bit              m_dr[$];
    bit              m_tdo;
    logic [DR_W-1:0] m_last_data;
    logic [IR_W-1:0] m_last_chain;
    logic [IR_W-1:0] exp_chain[$];
    logic [DR_W-1:0] exp_data[$];
    logic [IR_W-1:0] obs_chain[$];
    logic [DR_W-1:0] obs_data[$];
    logic            prev_valid = 1'b0;

    // Observed update pulses; a pulse must never last two cycles
    always @(negedge clk) begin
        if (upd_valid) begin
            obs_chain.push_back(upd_chain);
            obs_data.push_back(upd_data);
            chk("upd_pulse_width", prev_valid, 0);
        end
        prev_valid <= upd_valid;
    end

    task automatic model_reset();
        m_state = 0;
        m_ir = '1;
        m_irsr = '0;
        m_dr.delete();
        m_dr.push_back(1'b0);
        m_tdo = 1'b0;
        m_last_data = '0;
        m_last_chain = '0;
    endtask

    task automatic model_rise(input bit tms_v, input bit tdi_v);
        bit user;
        logic [DR_W-1:0] val;
        user = int'(m_ir) < CHAINS;
        case (m_state)
            3: begin
                m_dr.delete();
                if (user) for (int i = 0; i < DR_W; i++) m_dr.push_back(cap_data[int'(m_ir)*DR_W + i]);
                else m_dr.push_back(1'b0);
            end
            4: begin
                void'(m_dr.pop_front());
                m_dr.push_back(tdi_v);
            end
            8: if (user) begin
                val = '0;
                for (int i = 0; i < DR_W; i++) val[i] = m_dr[i];
                exp_chain.push_back(m_ir);
                exp_data.push_back(val);
                m_last_chain = m_ir;
                m_last_data = val;
            end
            10: m_irsr = IR_W'(1);
            11: m_irsr = {tdi_v, m_irsr[IR_W-1:1]};
            15: m_ir = m_irsr;
            default: ;
        endcase
        m_state = tms_v ? nxt1[m_state] : nxt0[m_state];
        if (m_state == 0) m_ir = '1;
    endtask

    task automatic model_fall();
        m_tdo = (m_state == 4) ? m_dr[0] : (m_state == 11) ? m_irsr[0] : 1'b0;
    endtask

    task automatic tck_cycle(input bit tms_v, input bit tdi_v, output bit tdo_v);
        chk("tdo", tdo, m_tdo);
        chk("tap_state", tap_state, m_state);
        tdo_v = tdo;
        tms = tms_v;
        tdi = tdi_v;
        #40 tck = 1'b1;
        model_rise(tms_v, tdi_v);
        #40 tck = 1'b0;
        model_fall();
        #40;
    endtask

    task automatic check_updates();
        chk("upd_count", obs_chain.size(), exp_chain.size());
        while (obs_chain.size() > 0 && exp_chain.size() > 0) begin
            chk("upd_chain", obs_chain.pop_front(), exp_chain.pop_front());
            chk("upd_data", obs_data.pop_front(), exp_data.pop_front());
        end
        obs_chain.delete(); obs_data.delete();
        exp_chain.delete(); exp_data.delete();
        chk("upd_chain_hold", upd_chain, m_last_chain);
        chk("upd_data_hold", upd_data, m_last_data);
    endtask

    // From RTI: load an instruction and return to RTI, returning the captured IR bits
    task automatic ir_scan(input logic [IR_W-1:0] val, output logic [IR_W-1:0] out);
        bit t;
        out = '0;
        tck_cycle(1, 0, t); tck_cycle(1, 0, t); tck_cycle(0, 0, t); tck_cycle(0, 0, t);
        for (int i = 0; i < IR_W; i++) begin
            tck_cycle(i == IR_W-1, val[i], t);
            out[i] = t;
        end
        tck_cycle(1, 0, t); tck_cycle(0, 0, t);
    endtask

    // From RTI: DR scan of n bits, optional 10-tck pause after pause_at bits, optional abort
    task automatic dr_scan(input logic [63:0] data, input int n, input int pause_at,
                           input int abort_at, output logic [63:0] out);
        bit t;
        out = '0;
        tck_cycle(1, 0, t); tck_cycle(0, 0, t); tck_cycle(0, 0, t);
        for (int i = 0; i < n; i++) begin
            tck_cycle((i == n-1) || (i == pause_at-1), data[i], t);
            out[i] = t;
            if (i == abort_at-1) return;
            if (i == pause_at-1 && i != n-1) begin
                tck_cycle(0, 0, t);
                repeat (10) tck_cycle(0, 0, t);
                tck_cycle(1, 0, t);
                tck_cycle(0, 0, t);
            end
        end
        tck_cycle(1, 0, t); tck_cycle(0, 0, t);
    endtask

    initial begin
        bit t;
        logic [IR_W-1:0] ir_out;
        logic [63:0] o;
        logic [63:0] d;
        int n, r;

        model_reset();
        #52;
        chk("rst_tap_state", tap_state, 0);
        chk("rst_tdo", tdo, 0);
        chk("rst_upd_valid", upd_valid, 0);
        chk("rst_upd_chain", upd_chain, 0);
        chk("rst_upd_data", upd_data, 0);
        rst = 1'b0;
        #40;

        repeat (5) tck_cycle(1, 0, t);
        chk("tlr_after_5", tap_state, 0);
        check_updates();
        tck_cycle(0, 0, t);

        cap_data = {32'hDEAD_BEEF, $urandom()};
        ir_scan(4'd1, ir_out);
        chk("ir_capture", ir_out, 4'b0001);
        dr_scan(64'hA5A5_1234, 32, 0, 0, o);
        chk("chain1_tdo", o[31:0], 32'hDEAD_BEEF);
        chk("chain1_count", obs_chain.size(), 1);
        chk("chain1_data", upd_data, 32'hA5A5_1234);
        chk("chain1_index", upd_chain, 1);
        check_updates();

        ir_scan(4'hF, ir_out);
        dr_scan(64'b1011_0010, 8, 0, 0, o);
        chk("bypass_tdo", o[7:0], 8'b0110_0100);
        check_updates();

        d = {32'h0, $urandom()};
        ir_scan(4'd0, ir_out);
        dr_scan(d, 32, 12, 0, o);
        chk("pause_tdo", o[31:0], cap_data[31:0]);
        chk("pause_data", upd_data, d[31:0]);
        check_updates();

        ir_scan(4'd1, ir_out);
        dr_scan({32'h0, $urandom()}, 32, 0, 16, o);
        rst = 1'b1;
        #1;
        chk("midrst_tap_state", tap_state, 0);
        model_reset();
        #60;
        chk("midrst_upd_valid", upd_valid, 0);
        rst = 1'b0;
        #40;
        check_updates();
        tck_cycle(0, 0, t);
        d = {32'h0, $urandom()};
        ir_scan(4'd1, ir_out);
        dr_scan(d, 32, 0, 0, o);
        chk("postrst_data", upd_data, d[31:0]);
        check_updates();

        for (int it = 0; it < 30; it++) begin
            r = $urandom_range(0, 2);
            if (r == 0) begin
                repeat (20) tck_cycle($urandom_range(0, 1), $urandom_range(0, 1), t);
                repeat (5) tck_cycle(1, 0, t);
                tck_cycle(0, 0, t);
            end else if (r == 1) begin
                ir_scan(IR_W'($urandom_range(0, 15)), ir_out);
            end else begin
                cap_data = {$urandom(), $urandom()};
                n = $urandom_range(1, 40);
                dr_scan({$urandom(), $urandom()}, n, $urandom_range(0, n-1), 0, o);
            end
            check_updates();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
